mtr_ramp_ctrl: RTL
==================

MTR_RAMP_CTRL -- requirements
Module: mtr_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 1024: clk cycles per ramp tick (>=2).
REQ-002 SHALL have parameter STEP, default 16: max speed change per tick in RAMP.
REQ-003 SHALL have parameter BRAKE_STEP, default 64: max speed change per tick in BRAKE.
REQ-004 SHALL have parameter MAX_SPD, default 12'd1800: symmetric speed saturation magnitude.
REQ-005 SHALL have parameter VBATT_MIN, default 12'hA00: undervoltage trip threshold.
REQ-006 SHALL have parameter VBATT_HYST, default 12'h040: undervoltage release hysteresis.
REQ-007 SHALL have one clock; reset is synchronous and active-low: clk  in  1  system clock.
REQ-008 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-009 SHALL have lft_cmd  in  12 signed  requested left speed.
REQ-010 SHALL have rght_cmd  in  12 signed  requested right speed.
REQ-011 SHALL have cmd_vld  in  1  one-cycle strobe qualifying lft_cmd/rght_cmd.
REQ-012 SHALL have en  in  1  motor enable level.
REQ-013 SHALL have estop  in  1  emergency stop level.
REQ-014 SHALL have vbatt  in  12  battery reading, unsigned.
REQ-015 SHALL have lft_spd  out  12 signed  registered left speed to motor driver.
REQ-016 SHALL have rght_spd  out  12 signed  registered right speed to motor driver.
REQ-017 SHALL have ramping  out  1  high in RAMP or BRAKE.
REQ-018 SHALL have fault  out  1  high in FAULT.
REQ-019 SHALL have batt_low  out  1  registered undervoltage flag.

Function
REQ-020 SHALL implement states IDLE, RAMP, HOLD, BRAKE, FAULT; priority each cycle: FAULT entry > BRAKE entry > other transitions.
REQ-021 SHALL enter FAULT from any state when estop=1 or batt_low=1, forcing lft_spd=rght_spd=0 the next cycle.
REQ-022 SHALL leave FAULT for IDLE only when estop=0, batt_low=0 and en=0 in the same cycle (re-arm).
REQ-023 SHALL, in IDLE, hold outputs at 0 and go to RAMP when en=1.
REQ-024 SHALL latch targets on cmd_vld in every state except FAULT, saturating each to [-MAX_SPD, +MAX_SPD].
REQ-025 SHALL clear targets to 0 on FAULT entry.
REQ-026 SHALL run a tick counter 0..RAMP_DIV-1 in RAMP and BRAKE, cleared to 0 on entry to either state; tick fires when count = RAMP_DIV-1.
REQ-027 SHALL, on each RAMP tick, move each output toward its target: set equal if |target-out| <= STEP, else change by STEP; difference computed at 13 bits.
REQ-028 SHALL go RAMP->HOLD in the cycle both outputs equal their targets; HOLD->RAMP on any cycle a target differs from its output.
REQ-029 SHALL go RAMP/HOLD->BRAKE when en=0; BRAKE ramps both outputs toward 0 using BRAKE_STEP, ignoring latched targets.
REQ-030 SHALL go BRAKE->IDLE when both outputs are 0; BRAKE->RAMP if en=1, continuing from current outputs without reset of outputs.
REQ-031 SHALL treat cmd_vld coincident with en falling as latched but not applied (BRAKE wins).
REQ-032 SHALL never change an output by more than STEP (RAMP) or BRAKE_STEP (BRAKE) per tick; sign reversal passes through intermediate values.
REQ-033 SHALL set batt_low when vbatt < VBATT_MIN and clear it when vbatt >= VBATT_MIN+VBATT_HYST; otherwise hold.

Reset
REQ-034 SHALL, when rst_n=0 at a clk edge, set state=IDLE, outputs/targets/counter=0, batt_low=0, ramping=0, fault=0.
REQ-035 SHALL apply reset mid-ramp identically, with no output glitch beyond the reset edge.

Verification (RAMP_DIV=4, STEP=16, BRAKE_STEP=64, MAX_SPD=1800)
REQ-036 en=1, cmd_vld with lft=100, rght=-40 -> lft 16,32,..,96,100 every 4 cycles; rght -16,-32,-40; HOLD after lft reaches 100.
REQ-037 cmd lft=2047 -> target saturates 1800; lft_spd never exceeds 1800.
REQ-038 at lft=100 hold, en=0 -> BRAKE, lft 36 then 0 on successive ticks, then IDLE, ramping=0.
REQ-039 mid-RAMP estop=1 -> next cycle outputs 0, fault=1; estop=0 with en=1 stays FAULT; en=0 -> IDLE.
REQ-040 vbatt 0xA10 -> 0x9FF sets batt_low and FAULT; 0xA20 keeps batt_low; 0xA40 clears it.
REQ-041 hold at lft=32, cmd lft=-32 -> 16, 0, -16, -32 on successive ticks.

Source files
------------

// File: rtl/mtr_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// mtr_ramp_ctrl_if
// Bundles the command, supervision and motor-drive signals of mtr_ramp_ctrl.
//   lft_cmd / rght_cmd : requested wheel speeds (signed 12b), qualified by
//                        the one-cycle strobe cmd_vld
//   en, estop          : motor enable level, emergency stop level
//   vbatt              : battery reading (unsigned 12b)
//   lft_spd / rght_spd : registered wheel speeds to the motor driver
//   ramping, fault     : status flags; batt_low : registered undervoltage flag
// master = command source / supervisor, slave = the ramp controller.
// ---------------------------------------------------------------------------
interface mtr_ramp_ctrl_if;
  logic signed [11:0] lft_cmd;
  logic signed [11:0] rght_cmd;
  logic               cmd_vld;
  logic               en;
  logic               estop;
  logic        [11:0] vbatt;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               ramping;
  logic               fault;
  logic               batt_low;

  modport master (
    output lft_cmd, rght_cmd, cmd_vld, en, estop, vbatt,
    input  lft_spd, rght_spd, ramping, fault, batt_low
  );

  modport slave (
    input  lft_cmd, rght_cmd, cmd_vld, en, estop, vbatt,
    output lft_spd, rght_spd, ramping, fault, batt_low
  );
endinterface

// File: rtl/mtr_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// mtr_ramp_ctrl
// Two-wheel speed ramp controller. Latched speed targets are approached in
// steps of at most STEP once every RAMP_DIV clocks; dropping en brakes both
// wheels to zero in steps of at most BRAKE_STEP. estop or a battery
// undervoltage forces both outputs to zero and holds the block in FAULT until
// it is re-armed (estop=0, batt_low=0, en=0).
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : mtr_ramp_ctrl_if.slave (commands, supervision inputs, speeds,
//           status flags)
// ---------------------------------------------------------------------------
module mtr_ramp_ctrl #(
  parameter int          RAMP_DIV   = 1024,
  parameter int          STEP       = 16,
  parameter int          BRAKE_STEP = 64,
  parameter logic [11:0] MAX_SPD    = 12'd1800,
  parameter logic [11:0] VBATT_MIN  = 12'hA00,
  parameter logic [11:0] VBATT_HYST = 12'h040
) (
  input  logic           clk,
  input  logic           rst_n,
  mtr_ramp_ctrl_if.slave bus
);

  localparam int CW = $clog2(RAMP_DIV);
  localparam logic [CW-1:0]      CNT_LAST  = CW'(RAMP_DIV - 1);
  localparam logic signed [12:0] STEP_W    = 13'(STEP);
  localparam logic signed [12:0] BSTEP_W   = 13'(BRAKE_STEP);
  localparam logic signed [11:0] SPD_POS   = $signed(MAX_SPD);
  localparam logic signed [11:0] SPD_NEG   = -SPD_POS;
  // Release threshold kept at 13 bits so MIN+HYST cannot wrap.
  localparam logic [12:0]        VBATT_REL = {1'b0, VBATT_MIN} + {1'b0, VBATT_HYST};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD,
    ST_BRAKE,
    ST_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic signed [11:0] lft_spd_q, lft_spd_d;
  logic signed [11:0] rght_spd_q, rght_spd_d;
  logic signed [11:0] lft_tgt_q, lft_tgt_d;
  logic signed [11:0] rght_tgt_q, rght_tgt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               batt_low_q, batt_low_d;

  logic               tick;
  logic [CW-1:0]      cnt_nxt;
  logic               at_tgt;
  logic               at_zero;

  // Move cur toward tgt by at most step; difference taken at 13 bits so a
  // full-scale reversal cannot overflow.
  function automatic logic signed [11:0] step_toward(
    input logic signed [11:0] cur,
    input logic signed [11:0] tgt,
    input logic signed [12:0] step
  );
    logic signed [12:0] diff;
    logic signed [12:0] nxt;
    diff = $signed({tgt[11], tgt}) - $signed({cur[11], cur});
    if (diff <= step && diff >= -step) begin
      nxt = $signed({tgt[11], tgt});
    end else if (diff > 13'sd0) begin
      nxt = $signed({cur[11], cur}) + step;
    end else begin
      nxt = $signed({cur[11], cur}) - step;
    end
    return nxt[11:0];
  endfunction

  function automatic logic signed [11:0] sat_spd(input logic signed [11:0] c);
    logic signed [11:0] r;
    r = c;
    if (c > SPD_POS) r = SPD_POS;
    if (c < SPD_NEG) r = SPD_NEG;
    return r;
  endfunction

  assign tick    = (cnt_q == CNT_LAST);
  assign cnt_nxt = tick ? '0 : cnt_q + 1'b1;
  assign at_tgt  = (lft_spd_q == lft_tgt_q) && (rght_spd_q == rght_tgt_q);
  assign at_zero = (lft_spd_q == '0) && (rght_spd_q == '0);

  // Undervoltage flag with hysteresis.
  always_comb begin
    batt_low_d = batt_low_q;
    if (bus.vbatt < VBATT_MIN) begin
      batt_low_d = 1'b1;
    end else if ({1'b0, bus.vbatt} >= VBATT_REL) begin
      batt_low_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lft_spd_d  = lft_spd_q;
    rght_spd_d = rght_spd_q;
    lft_tgt_d  = lft_tgt_q;
    rght_tgt_d = rght_tgt_q;
    cnt_d      = cnt_q;

    if (bus.estop || batt_low_q) begin
      state_d    = ST_FAULT;
      lft_spd_d  = '0;
      rght_spd_d = '0;
      lft_tgt_d  = '0;
      rght_tgt_d = '0;
      cnt_d      = '0;
    end else begin
      // Latching never affects this cycle's step; it uses the old targets.
      if (bus.cmd_vld && state_q != ST_FAULT) begin
        lft_tgt_d  = sat_spd(bus.lft_cmd);
        rght_tgt_d = sat_spd(bus.rght_cmd);
      end

      unique case (state_q)
        ST_IDLE: begin
          lft_spd_d  = '0;
          rght_spd_d = '0;
          if (bus.en) begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end
        end
        ST_RAMP: begin
          if (!bus.en) begin
            state_d = ST_BRAKE;
            cnt_d   = '0;
          end else if (at_tgt) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_nxt;
            if (tick) begin
              lft_spd_d  = step_toward(lft_spd_q, lft_tgt_q, STEP_W);
              rght_spd_d = step_toward(rght_spd_q, rght_tgt_q, STEP_W);
            end
          end
        end
        ST_HOLD: begin
          if (!bus.en) begin
            state_d = ST_BRAKE;
            cnt_d   = '0;
          end else if (!at_tgt) begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end
        end
        ST_BRAKE: begin
          if (bus.en) begin
            state_d = ST_RAMP;
            cnt_d   = '0;
          end else if (at_zero) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_nxt;
            if (tick) begin
              lft_spd_d  = step_toward(lft_spd_q, '0, BSTEP_W);
              rght_spd_d = step_toward(rght_spd_q, '0, BSTEP_W);
            end
          end
        end
        ST_FAULT: begin
          lft_spd_d  = '0;
          rght_spd_d = '0;
          if (!bus.en) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      lft_tgt_q  <= '0;
      rght_tgt_q <= '0;
      cnt_q      <= '0;
      batt_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
      lft_tgt_q  <= lft_tgt_d;
      rght_tgt_q <= rght_tgt_d;
      cnt_q      <= cnt_d;
      batt_low_q <= batt_low_d;
    end
  end

  assign bus.lft_spd  = lft_spd_q;
  assign bus.rght_spd = rght_spd_q;
  assign bus.ramping  = (state_q == ST_RAMP) || (state_q == ST_BRAKE);
  assign bus.fault    = (state_q == ST_FAULT);
  assign bus.batt_low = batt_low_q;

endmodule
